// File: rtl/aes_blk_host_if.sv
// Block-interface bundle for aes_blk_host.
// It carries the upstream stream, the flow-controller offer/result path,
// the downstream stream, and the status/error flags.
// slave  = the host block's view; master = the environment driving it.
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 128
`endif

interface aes_blk_host_if #(
  parameter int BW = `BLOCK_DATA_WIDTH
);
  logic [BW-1:0] up_data;
  logic          up_vld;
  logic          up_rdy;
  logic [BW-1:0] block_data_in;
  logic          block_data_in_vld;
  logic          data_accept;
  logic [BW-1:0] data_out;
  logic          data_out_vld;
  logic [BW-1:0] dn_data;
  logic          dn_vld;
  logic          dn_rdy;
  logic          busy;
  logic          err_clr;
  logic          err_unexp;
  logic          timeout_err;

  modport slave (
    input  up_data, up_vld, data_accept, data_out, data_out_vld, dn_rdy, err_clr,
    output up_rdy, block_data_in, block_data_in_vld, dn_data, dn_vld, busy,
           err_unexp, timeout_err
  );

  modport master (
    output up_data, up_vld, data_accept, data_out, data_out_vld, dn_rdy, err_clr,
    input  up_rdy, block_data_in, block_data_in_vld, dn_data, dn_vld, busy,
           err_unexp, timeout_err
  );
endinterface

// File: rtl/aes_blk_host.sv
// aes_blk_host: host-side block transmitter/collector for the AES flow controller.
// A 2-entry queue feeds one block at a time to the flow controller.
// The returned result lands in a single output register drained downstream.
// Optional watchdog on the BUSY wait is enabled by defining AES_HOST_TIMEOUT_EN.
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 128
`endif

module aes_blk_host #(
  parameter int BW      = `BLOCK_DATA_WIDTH,
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  aes_blk_host_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} state_t;

  state_t        r_state;
  logic          r_offer;
  logic          r_busy;
  logic [BW-1:0] r_dn_data;
  logic          r_dn_vld;
  logic          r_err_unexp;
  logic [BW-1:0] r_mem [2];
  logic [1:0]    r_count;
  logic          r_rd_ptr;
  logic          r_wr_ptr;

  logic w_up_rdy;
  logic w_push;
  logic w_pop;
  logic w_out_free;
  logic w_capture;
  logic w_err_set;
  logic w_tmo_fire;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("aes_blk_host: TIMEOUT must lie in 2..65535");
  end

  assign w_up_rdy   = (r_count != 2'd2);
  assign w_push     = bus.up_vld && w_up_rdy;
  assign w_pop      = (r_state == S_OFFER) && bus.data_accept;
  // The result register may be reused if it is empty or draining this cycle.
  assign w_out_free = !r_dn_vld || bus.dn_rdy;
  assign w_capture  = (r_state == S_BUSY) && bus.data_out_vld;
  assign w_err_set  = (bus.data_accept && (r_state != S_OFFER)) ||
                      (bus.data_out_vld && (r_state != S_BUSY));

`ifdef AES_HOST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_tmo_cnt;
  logic        r_tmo_err;

  // A result arriving on the deadline cycle takes precedence over the watchdog.
  assign w_tmo_fire = (r_state == S_BUSY) && !bus.data_out_vld && (r_tmo_cnt == TMO_LAST);

  // Count cycles spent waiting in BUSY; restart on every launch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (w_pop) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Sticky watchdog flag; a firing in the clear cycle keeps it set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_err <= 1'b0;
    end else if (w_tmo_fire) begin
      r_tmo_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_tmo_err <= 1'b0;
    end
  end

  assign bus.timeout_err = r_tmo_err;
`else
  assign w_tmo_fire      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Queue occupancy and pointers; a full queue refuses pushes even while popping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are qualified by r_count so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.up_data;
  end

  // Offer/busy sequencing plus the result register it guards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_offer   <= 1'b0;
      r_busy    <= 1'b0;
      r_dn_data <= '0;
      r_dn_vld  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_dn_data <= bus.data_out;
        r_dn_vld  <= 1'b1;
      end else if (bus.dn_rdy) begin
        r_dn_vld  <= 1'b0;
      end
      case (r_state)
        // A block pushed this cycle counts, so an empty queue offers one cycle after the push.
        S_IDLE: begin
          if ((r_count != 2'd0 || w_push) && w_out_free) begin
            r_state <= S_OFFER;
            r_offer <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_OFFER: begin
          if (bus.data_accept) begin
            r_state <= S_BUSY;
            r_offer <= 1'b0;
          end
        end
        S_BUSY: begin
          if (w_capture || w_tmo_fire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_offer <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol-violation flag; a new violation beats a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_unexp <= 1'b0;
    end else if (w_err_set) begin
      r_err_unexp <= 1'b1;
    end else if (bus.err_clr) begin
      r_err_unexp <= 1'b0;
    end
  end

  assign bus.up_rdy            = w_up_rdy;
  assign bus.block_data_in     = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign bus.block_data_in_vld = r_offer;
  assign bus.busy              = r_busy;
  assign bus.dn_data           = r_dn_data;
  assign bus.dn_vld            = r_dn_vld;
  assign bus.err_unexp         = r_err_unexp;

endmodule

// File: doc/aes_blk_host.md
# aes_blk_host

Host-side block transmitter/collector for the AES flow controller's block interface. Accepts 128-bit plaintext blocks from an upstream valid/ready stream into a 2-entry queue. Offers each block to the flow controller on `block_data_in`/`block_data_in_vld` and holds it until `data_accept`. Captures the returned `data_out` on `data_out_vld` into an output register drained by a downstream valid/ready stream; one block in flight at a time.

## Interface
Parameters:
- `BW`, default `` `BLOCK_DATA_WIDTH`` (128): block width.
- `TIMEOUT`, default 1024: cycles allowed in BUSY before watchdog fires (range 2..65535).

Ports:
- `clock`  in  1  system clock, all state on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `up_data`  in  BW  plaintext block from upstream.
- `up_vld`  in  1  upstream block valid.
- `up_rdy`  out  1  queue not full.
- `block_data_in`  out  BW  block offered to the flow controller (queue head).
- `block_data_in_vld`  out  1  offer valid.
- `data_accept`  in  1  flow controller took the offered block.
- `data_out`  in  BW  result block from the flow controller.
- `data_out_vld`  in  1  result valid, single-cycle pulse, no backpressure.
- `dn_data`  out  BW  captured result.
- `dn_vld`  out  1  result register full.
- `dn_rdy`  in  1  downstream takes result.
- `busy`  out  1  state is OFFER or BUSY.
- `err_clr`  in  1  clears sticky error flags.
- `err_unexp`  out  1  sticky: protocol violation seen.
- `timeout_err`  out  1  sticky: watchdog fired.

## Operation
- Queue: 2-entry FIFO with count 0..2. `up_rdy` = (count != 2). Push on `up_vld && up_rdy`. Pop on accept in OFFER. Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, OFFER, BUSY.
  - IDLE -> OFFER when count != 0 and output register free. Output register is free when `!dn_vld`, or when `dn_vld && dn_rdy` in the same cycle.
  - OFFER: `block_data_in_vld`=1, `block_data_in`=queue head, held stable. On `data_accept`: pop, go to BUSY.
  - BUSY: wait for `data_out_vld`. On it: `dn_data`<=`data_out`, `dn_vld`<=1, go to IDLE.
- Output register cannot be overwritten. Launch requires it free, and nothing else fills it before the result arrives.
- `dn_vld` clears on `dn_rdy`. In BUSY, a capture in the same cycle as a drain is impossible (register already empty).
- `err_unexp` set on `data_accept` outside OFFER, or `data_out_vld` outside BUSY. The stray `data_out` is dropped.
- `err_clr` clears both sticky flags; a set event in the same cycle wins.
- `block_data_in` = queue head whenever count != 0, else 0.

## Timing
- Reset values: `up_rdy`=1 (queue empty), `block_data_in`=0, `block_data_in_vld`=0, `dn_data`=0, `dn_vld`=0, `busy`=0, `err_unexp`=0, `timeout_err`=0. FSM=IDLE, count=0.
- Push at cycle N (empty queue, IDLE, output free) -> `block_data_in_vld`=1 at N+1.
- `data_accept` at cycle A -> BUSY at A+1. `block_data_in_vld`=0 at A+1 (IDLE first; earliest re-offer A+2 after result).
- `data_out_vld` at cycle M -> `dn_vld`=1, `dn_data` valid at M+1. IDLE at M+1, next OFFER earliest M+2.
- `up_rdy` is combinational from count only. Full queue: `up_rdy`=0 even if a pop occurs that cycle.
- Reset mid-operation: everything returns to reset values. Queued and in-flight blocks are lost, and any late `data_out_vld` afterwards flags `err_unexp`.

## Configuration
- `AES_HOST_TIMEOUT_EN` defined: 16-bit counter cleared on BUSY entry and incremented each BUSY cycle. At count == `TIMEOUT`-1 without `data_out_vld`:
  - set `timeout_err`;
  - go to IDLE;
  - discard the in-flight block.

  `data_out_vld` in that same cycle wins: normal capture, no error.
- Not defined: no counter; `timeout_err` tied 0; BUSY waits indefinitely.

## Test plan
- Single block: push 128'h00112233445566778899aabbccddeeff; model accepts 1 cycle after offer and returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles later. Required: `dn_data` equals the returned value one cycle after `data_out_vld`; `dn_vld` held until `dn_rdy`.
- Queue full: push 3 blocks back-to-back with model never accepting. Required: `up_rdy`=0 after the 2nd push, 3rd push stalled, `block_data_in` stays block 1.
- Downstream stall: `dn_rdy`=0 while 2 blocks are queued. Required: 2nd block not offered until the cycle `dn_rdy`=1 drains result 1; offer at the next cycle.
- Protocol errors: `data_out_vld` pulse while IDLE. Required: `err_unexp`=1 next cycle, `dn_vld` stays 0; `err_clr` returns it to 0.
- Watchdog (macro on, `TIMEOUT`=8): accept, never return. Required: `timeout_err`=1 and `busy`=0 8 cycles after BUSY entry. With the macro off, the same stimulus gives `busy`=1 indefinitely.
- Reset mid-BUSY: assert `reset` low for 1 cycle. Required: all outputs at reset values while `reset` is low and after release; a later `data_out_vld` sets `err_unexp`.
